// File: rtl/odometer_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : odometer_pulse_gen
// Description : Wheel-tick conditioning (sync + debounce or simulated wheel),
//               10 m divider, min-width pulse shaper and idle/wait detector.
// Revision    : 1.0 - initial release
// ============================================================================
module odometer_pulse_gen #(
  parameter int DEBOUNCE_CYCLES     = 1000,
  parameter int PULSES_PER_10M      = 4,
  parameter int PULSE_HIGH_CYCLES   = 4,
  parameter int WAIT_TIMEOUT_CYCLES = 50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        wheel_in,
  input  logic        sim_en,
  input  logic [23:0] sim_period,
  output logic        ten_meter_pulse,
  output logic        wait_en,
  output logic        overrun
);

  localparam int c_deb_w = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int c_div_w = $clog2(PULSES_PER_10M) + 1;
  localparam int c_ph_w  = $clog2(PULSE_HIGH_CYCLES) + 1;
  localparam int c_tmr_w = $clog2(WAIT_TIMEOUT_CYCLES) + 1;

  localparam logic [c_deb_w-1:0] c_deb_max  = c_deb_w'(DEBOUNCE_CYCLES);
  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(PULSES_PER_10M - 1);
  localparam logic [c_ph_w-1:0]  c_ph_last  = c_ph_w'(PULSE_HIGH_CYCLES - 1);
  localparam logic [c_tmr_w-1:0] c_tmr_max  = c_tmr_w'(WAIT_TIMEOUT_CYCLES);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_high = 2'd1;
  localparam logic [1:0] c_st_gap  = 2'd2;

  logic               r_sync1;
  logic               r_sync2;
  logic [c_deb_w-1:0] r_deb_cnt;
  logic [c_deb_w-1:0] w_deb_cnt_inc;
  logic               r_deb_level;
  logic               r_deb_level_d;
  logic               w_raw_tick;

  logic [23:0]        r_sim_cnt;
  logic [23:0]        r_sim_period_q;
  logic               w_sim_run;
  logic               w_sim_tick;
  logic               w_tick;

  logic [c_div_w-1:0] r_div;
  logic               w_event;

  logic [1:0]         r_state;
  logic [1:0]         w_state_next;
  logic [c_ph_w-1:0]  r_phase;
  logic               w_phase_last;
  logic               w_busy_mid;
  logic               r_pending;
  logic               r_overrun;

  logic [c_tmr_w-1:0] r_timer;

  // Synchroniser and debounce: level only moves after a full run of mismatches
  assign w_deb_cnt_inc = r_deb_cnt + c_deb_w'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1       <= 1'b0;
      r_sync2       <= 1'b0;
      r_deb_cnt     <= '0;
      r_deb_level   <= 1'b0;
      r_deb_level_d <= 1'b0;
    end else begin
      r_sync1       <= wheel_in;
      r_sync2       <= r_sync1;
      r_deb_level_d <= r_deb_level;
      if (r_sync2 != r_deb_level) begin
        if (w_deb_cnt_inc == c_deb_max) begin
          r_deb_level <= r_sync2;
          r_deb_cnt   <= '0;
        end else begin
          r_deb_cnt <= w_deb_cnt_inc;
        end
      end else begin
        r_deb_cnt <= '0;
      end
    end
  end

  assign w_raw_tick = r_deb_level & ~r_deb_level_d;

  // Simulated wheel; a period change holds the counter at 0 for that cycle
  assign w_sim_run  = sim_en && (sim_period != 24'd0) && (sim_period == r_sim_period_q);
  assign w_sim_tick = w_sim_run && (r_sim_cnt == sim_period - 24'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sim_cnt      <= '0;
      r_sim_period_q <= '0;
    end else begin
      r_sim_period_q <= sim_period;
      if (!w_sim_run || w_sim_tick) begin
        r_sim_cnt <= '0;
      end else begin
        r_sim_cnt <= r_sim_cnt + 24'd1;
      end
    end
  end

  assign w_tick  = sim_en ? w_sim_tick : w_raw_tick;
  assign w_event = en && w_tick && (r_div == c_div_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div <= '0;
    end else if (en && w_tick) begin
      r_div <= w_event ? '0 : r_div + c_div_w'(1);
    end
  end

  // Pulse shaper FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_st_idle;
      r_phase <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_state_next != r_state) begin
        r_phase <= '0;
      end else if (r_state != c_st_idle) begin
        r_phase <= r_phase + c_ph_w'(1);
      end
    end
  end

  assign w_phase_last = (r_phase == c_ph_last);
  assign w_busy_mid   = (r_state == c_st_high) || ((r_state == c_st_gap) && !w_phase_last);

  // Pulse shaper FSM: next state; the last GAP cycle chains straight into HIGH
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_idle: if (w_event) w_state_next = c_st_high;
      c_st_high: if (w_phase_last) w_state_next = c_st_gap;
      c_st_gap:  if (w_phase_last) begin
        w_state_next = (en && (r_pending || w_event)) ? c_st_high : c_st_idle;
      end
      default:   w_state_next = c_st_idle;
    endcase
  end

  // Pulse shaper FSM: outputs
  always_comb begin
    ten_meter_pulse = (r_state == c_st_high);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (!en) begin
        r_pending <= 1'b0;
      end else if ((r_state == c_st_gap) && w_phase_last) begin
        r_pending <= r_pending && w_event;
      end else if (w_busy_mid && w_event) begin
        r_pending <= 1'b1;
      end
      if (w_busy_mid && w_event && r_pending) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign overrun = r_overrun;

  // Idle timer saturates at the timeout; a tick always wins over reaching it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer <= '0;
    end else if (!en || w_tick) begin
      r_timer <= '0;
    end else if (r_timer != c_tmr_max) begin
      r_timer <= r_timer + c_tmr_w'(1);
    end
  end

  assign wait_en = (r_timer == c_tmr_max);

endmodule
`default_nettype wire

// File: tb/tb_odometer_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_odometer_pulse_gen
// Description : Self-checking bench; two DUTs (high width 2 and 3) against a
//               schedule-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_odometer_pulse_gen;

  localparam int c_deb = 4;
  localparam int c_ppm = 4;
  localparam int c_tmo = 20;
  localparam int c_hi0 = 2;
  localparam int c_hi1 = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        wheel_in;
  logic        sim_en;
  logic [23:0] sim_period;
  logic        pulse0, wait0, ovr0;
  logic        pulse1, wait1, ovr1;

  always #5 clk = ~clk;

  odometer_pulse_gen #(
    .DEBOUNCE_CYCLES(c_deb), .PULSES_PER_10M(c_ppm),
    .PULSE_HIGH_CYCLES(c_hi0), .WAIT_TIMEOUT_CYCLES(c_tmo)
  ) u_dut (
    .clk(clk), .rst(rst), .en(en), .wheel_in(wheel_in), .sim_en(sim_en),
    .sim_period(sim_period), .ten_meter_pulse(pulse0), .wait_en(wait0), .overrun(ovr0)
  );

  odometer_pulse_gen #(
    .DEBOUNCE_CYCLES(c_deb), .PULSES_PER_10M(c_ppm),
    .PULSE_HIGH_CYCLES(c_hi1), .WAIT_TIMEOUT_CYCLES(c_tmo)
  ) u_dut_h3 (
    .clk(clk), .rst(rst), .en(en), .wheel_in(wheel_in), .sim_en(sim_en),
    .sim_period(sim_period), .ten_meter_pulse(pulse1), .wait_en(wait1), .overrun(ovr1)
  );

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: sync/debounce by run length, sim ticks by cycle arithmetic,
  // pulses as a schedule of start times with a one-deep pending slot.
  int  m_cyc = 0;
  bit  m_s1, m_s2, m_dl, m_dl_d;
  int  m_run, m_prev_per, m_sim_ref, m_div, m_since;
  int  m_start [2];
  bit  m_pend  [2];
  bit  m_ovr   [2];
  bit  e_pulse [2];
  bit  e_ovr   [2];
  bit  e_wait;
  int  hi_len  [2] = '{c_hi0, c_hi1};

  always @(posedge clk) begin : p_model
    bit tick, ev;
    int per, last;
    per = int'(sim_period);
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_dl = 0; m_dl_d = 0; m_run = 0;
      m_prev_per = 0; m_sim_ref = m_cyc + 1; m_div = 0; m_since = 0;
      for (int i = 0; i < 2; i++) begin
        m_start[i] = -1000; m_pend[i] = 0; m_ovr[i] = 0;
      end
    end else begin
      if (sim_en) tick = (per != 0) && (per == m_prev_per) && ((m_cyc - m_sim_ref) % per == per - 1);
      else        tick = m_dl && !m_dl_d;
      ev = 0;
      if (en && tick) begin
        m_div++;
        ev = (m_div % c_ppm == 0);
      end
      for (int i = 0; i < 2; i++) begin
        last = m_start[i] + 2 * hi_len[i] - 1;
        if (!en) m_pend[i] = 0;
        if (m_cyc < last) begin
          if (ev) begin
            if (m_pend[i]) m_ovr[i] = 1;
            else           m_pend[i] = 1;
          end
        end else if (m_cyc == last) begin
          if (en && (m_pend[i] || ev)) begin
            m_start[i] = m_cyc + 1;
            m_pend[i]  = m_pend[i] && ev;
          end
        end else if (ev) begin
          m_start[i] = m_cyc + 1;
        end
      end
      m_since = (!en || tick) ? 0 : m_since + 1;
      if (!sim_en || per == 0 || per != m_prev_per) m_sim_ref = m_cyc + 1;
      m_prev_per = per;
      m_dl_d = m_dl;
      if (m_s2 != m_dl) begin
        m_run++;
        if (m_run == c_deb) begin
          m_dl  = m_s2;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
      m_s2 = m_s1;
      m_s1 = wheel_in;
    end
    m_cyc++;
    for (int i = 0; i < 2; i++) begin
      e_pulse[i] = (m_cyc >= m_start[i]) && (m_cyc < m_start[i] + hi_len[i]);
      e_ovr[i]   = m_ovr[i];
    end
    e_wait = (m_since >= c_tmo);
  end

  int n_rise = 0;
  bit prev0  = 0;

  always @(negedge clk) begin
    check("pulse_h2", 32'(pulse0), 32'(e_pulse[0]));
    check("wait_h2",  32'(wait0),  32'(e_wait));
    check("ovr_h2",   32'(ovr0),   32'(e_ovr[0]));
    check("pulse_h3", 32'(pulse1), 32'(e_pulse[1]));
    check("wait_h3",  32'(wait1),  32'(e_wait));
    check("ovr_h3",   32'(ovr1),   32'(e_ovr[1]));
    if (pulse0 && !prev0) n_rise++;
    prev0 = pulse0;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int base;
    int len;
    rst = 1'b1; en = 1'b0; wheel_in = 1'b0; sim_en = 1'b0; sim_period = 24'd0;
    cycles(3);
    check("rst_pulse", 32'(pulse0), 0);
    check("rst_wait",  32'(wait0),  0);
    check("rst_ovr",   32'(ovr0),   0);
    rst = 1'b0;
    en  = 1'b1;

    // Clean raw wheel: 8 rising edges give two 10 m pulses
    base = n_rise;
    for (int k = 0; k < 8; k++) begin
      wheel_in = 1'b1; cycles(10);
      wheel_in = 1'b0; cycles(10);
    end
    check("raw_clean_pulses", 32'(n_rise - base), 2);

    // Bouncy raw wheel: short glitches inside stable phases add nothing
    base = n_rise;
    for (int k = 0; k < 8; k++) begin
      wheel_in = 1'b1; cycles(5);
      wheel_in = 1'b0; cycles($urandom_range(1, 3));
      wheel_in = 1'b1; cycles(6);
      wheel_in = 1'b0; cycles(5);
      wheel_in = 1'b1; cycles($urandom_range(1, 3));
      wheel_in = 1'b0; cycles(6);
    end
    check("raw_bounce_pulses", 32'(n_rise - base), 2);

    // Simulated wheel, period 3: 16 ticks, 4 pulses; then stop and time out
    base = n_rise;
    sim_en = 1'b1; sim_period = 24'd3;
    cycles(49);
    sim_period = 24'd0;
    cycles(30);
    check("sim_pulses", 32'(n_rise - base), 4);
    check("sim_stop_wait", 32'(wait0), 1);

    // Tick every cycle: width 2 keeps up, width 3 overruns
    sim_period = 24'd1;
    cycles(40);
    check("fast_ovr_h2", 32'(ovr0), 0);
    check("fast_ovr_h3", 32'(ovr1), 1);

    // Enable drop in the middle of a HIGH phase
    len = 0;
    while (!pulse0 && len < 20) begin
      cycles(1);
      len++;
    end
    check("found_high", 32'(pulse0), 1);
    en = 1'b0;
    cycles(10);
    check("en_off_wait", 32'(wait0), 0);
    en = 1'b1;
    sim_period = 24'd0;
    cycles(25);
    check("idle_wait", 32'(wait0), 1);
    sim_period = 24'd2;
    cycles(4);
    check("tick_clears_wait", 32'(wait0), 0);

    // Reset in HIGH with work pending
    sim_period = 24'd1;
    cycles(12);
    len = 0;
    while (!pulse1 && len < 20) begin
      cycles(1);
      len++;
    end
    rst = 1'b1;
    cycles(1);
    check("mid_rst_pulse", 32'(pulse1), 0);
    check("mid_rst_ovr",   32'(ovr1),   0);
    rst = 1'b0;
    cycles(30);

    // Randomised mix of sources, enables, periods, wheel chatter and resets
    for (int s = 0; s < 60; s++) begin
      en         = ($urandom_range(0, 9) != 0);
      sim_en     = 1'($urandom_range(0, 1));
      sim_period = 24'($urandom_range(0, 6));
      len        = $urandom_range(10, 60);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 5) == 0) wheel_in = ~wheel_in;
        rst = ($urandom_range(0, 199) == 0);
        cycles(1);
      end
      rst = 1'b0;
    end

    cycles(2);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
